// File: rtl/pulse_stretch_fsmd_pkg.sv
// Shared definitions for the pulse stretcher: state encoding and default timing at 100 MHz.
package pulse_stretch_fsmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ON   = 2'b01,
    ST_GAP  = 2'b10
  } state_e;

  localparam int CNT_W_DEFAULT = 21;
  localparam int ON_CNT_20MS   = 2000000;
  localparam int GAP_CNT_10MS  = 1000000;

  // A duration of n cycles is counted from n-1 down to 0; zero cycles loads zero.
  function automatic int unsigned load_of(input int unsigned n_cycles);
    if (n_cycles == 32'd0) begin
      return 32'd0;
    end else begin
      return n_cycles - 32'd1;
    end
  endfunction

endpackage

// File: rtl/load_dec_counter.sv
// Loadable down-counter that saturates at zero and reports a zero flag.
module load_dec_counter #(
  parameter int N = 21
) (
  input  logic         i_CLK,
  input  logic         i_RST,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dec,
  input  logic         clr,
  output logic         zero
);

  localparam logic [N-1:0] ONE = N'(1);

  logic [N-1:0] cnt_r;

  // Count register: clear beats load, load beats decrement.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (dec && (cnt_r != '0)) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/pulse_stretch_fsmd.sv
// Stretches a one-cycle tick into a fixed-length level pulse followed by an enforced low gap.
module pulse_stretch_fsmd
  import pulse_stretch_fsmd_pkg::*;
#(
  parameter int N       = CNT_W_DEFAULT,
  parameter int ON_CNT  = ON_CNT_20MS,
  parameter int GAP_CNT = GAP_CNT_10MS,
  parameter int RETRIG  = 0
) (
  input  logic i_CLK,
  input  logic i_RST,
  input  logic i_TICK,
  input  logic i_ABORT,
  output logic o_LVL,
  output logic o_BUSY,
  output logic o_DONE_TICK,
  output logic o_DROP_TICK
);

  localparam logic [N-1:0] ON_LOAD    = N'(load_of(ON_CNT));
  localparam logic [N-1:0] GAP_LOAD   = N'(load_of(GAP_CNT));
  localparam bit           GAP_EN     = (GAP_CNT != 0);
  localparam bit           RETRIG_EN  = (RETRIG != 0);

  state_e       state_r;
  state_e       next_state_s;
  logic         cnt_load_s;
  logic [N-1:0] cnt_load_val_s;
  logic         cnt_dec_s;
  logic         cnt_clr_s;
  logic         cnt_zero_s;
  logic         done_s;
  logic         drop_s;

  load_dec_counter #(.N(N)) u_cnt (
    .i_CLK    (i_CLK),
    .i_RST    (i_RST),
    .load     (cnt_load_s),
    .load_val (cnt_load_val_s),
    .dec      (cnt_dec_s),
    .clr      (cnt_clr_s),
    .zero     (cnt_zero_s)
  );

  // Next-state decision and counter control; abort overrides everything, including a same-cycle tick.
  always_comb begin
    next_state_s   = state_r;
    cnt_load_s     = 1'b0;
    cnt_load_val_s = ON_LOAD;
    cnt_dec_s      = 1'b0;
    cnt_clr_s      = 1'b0;
    done_s         = 1'b0;
    drop_s         = 1'b0;
    if (i_ABORT) begin
      next_state_s = ST_IDLE;
      cnt_clr_s    = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (i_TICK) begin
            next_state_s = ST_ON;
            cnt_load_s   = 1'b1;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_ON: begin
          if (i_TICK && RETRIG_EN) begin
            // Retrigger wins even on the final high cycle, so no done tick then.
            cnt_load_s = 1'b1;
          end else begin
            drop_s = i_TICK;
            if (cnt_zero_s) begin
              done_s = 1'b1;
              if (GAP_EN) begin
                next_state_s   = ST_GAP;
                cnt_load_s     = 1'b1;
                cnt_load_val_s = GAP_LOAD;
              end else begin
                next_state_s = ST_IDLE;
              end
            end else begin
              cnt_dec_s = 1'b1;
            end
          end
        end
        ST_GAP: begin
          drop_s = i_TICK;
          if (cnt_zero_s) begin
            next_state_s = ST_IDLE;
          end else begin
            cnt_dec_s = 1'b1;
          end
        end
        default: begin
          next_state_s = ST_IDLE;
          cnt_clr_s    = 1'b1;
        end
      endcase
    end
  end

  // State register with outputs decoded from the next state so they line up with it.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_r     <= ST_IDLE;
      o_LVL       <= 1'b0;
      o_BUSY      <= 1'b0;
      o_DONE_TICK <= 1'b0;
      o_DROP_TICK <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      o_LVL       <= (next_state_s == ST_ON);
      o_BUSY      <= (next_state_s != ST_IDLE);
      o_DONE_TICK <= done_s;
      o_DROP_TICK <= drop_s;
    end
  end

endmodule

// File: tb/tb_pulse_stretch_fsmd.sv
// Self-checking bench: three configurations (base, retrigger, no gap) driven from per-cycle vector tables.
module tb_pulse_stretch_fsmd;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] tick;
  logic [2:0] abort;
  logic [2:0] lvl, busy, done, drop;

  always #5 clk = ~clk;

  pulse_stretch_fsmd #(.N(4), .ON_CNT(4), .GAP_CNT(3), .RETRIG(0)) u_base (
    .i_CLK(clk), .i_RST(rst), .i_TICK(tick[0]), .i_ABORT(abort[0]),
    .o_LVL(lvl[0]), .o_BUSY(busy[0]), .o_DONE_TICK(done[0]), .o_DROP_TICK(drop[0]));

  pulse_stretch_fsmd #(.N(4), .ON_CNT(4), .GAP_CNT(3), .RETRIG(1)) u_retrig (
    .i_CLK(clk), .i_RST(rst), .i_TICK(tick[1]), .i_ABORT(abort[1]),
    .o_LVL(lvl[1]), .o_BUSY(busy[1]), .o_DONE_TICK(done[1]), .o_DROP_TICK(drop[1]));

  pulse_stretch_fsmd #(.N(4), .ON_CNT(4), .GAP_CNT(0), .RETRIG(0)) u_nogap (
    .i_CLK(clk), .i_RST(rst), .i_TICK(tick[2]), .i_ABORT(abort[2]),
    .o_LVL(lvl[2]), .o_BUSY(busy[2]), .o_DONE_TICK(done[2]), .o_DROP_TICK(drop[2]));

  // exp = {lvl, busy, done, drop} expected in the cycle after the inputs are applied
  typedef struct packed {
    logic [3:0] scen;
    logic [4:0] idx;
    logic [1:0] sel;
    logic       tick;
    logic       abort;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [3:0] outs(input logic [1:0] s);
    return {lvl[s], busy[s], done[s], drop[s]};
  endfunction

  function automatic logic [3:0] hexc(input byte c);
    if (c >= 8'h41) return 4'(c - 8'h41 + 8'd10);
    else            return 4'(c - 8'h30);
  endfunction

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: lvl/busy/done/drop got %b, expected %b", name, act, exp);
    end
  endtask

  // One char per cycle: ticks/aborts '1' = asserted, exps one hex digit of {lvl,busy,done,drop}.
  task automatic add_seq(input int scen, input logic [1:0] sel,
                         input string ticks, input string aborts, input string exps);
    vec_t v;
    for (int k = 0; k < exps.len(); k++) begin
      v.scen  = 4'(scen);
      v.idx   = 5'(k);
      v.sel   = sel;
      v.tick  = (k < ticks.len())  && (ticks[k]  == 8'h31);
      v.abort = (k < aborts.len()) && (aborts[k] == 8'h31);
      v.exp   = hexc(exps[k]);
      vecs.push_back(v);
    end
  endtask

  initial begin
    vec_t e;
    rst   = 1'b1;
    tick  = 3'b000;
    abort = 3'b000;

    add_seq(1, 2'd0, "10000000",         "",         "CCCC6440");         // basic pulse
    add_seq(2, 2'd0, "10100000",         "",         "CCDC6440");         // dropped tick in ON
    add_seq(3, 2'd1, "10010000000",      "",         "CCCCCCC6440");      // retrigger mid-ON
    add_seq(4, 2'd0, "1000001110000000", "",         "CCCC6451CCCC6440"); // gap ticks, final gap cycle, new pulse
    add_seq(5, 2'd0, "1010000",          "0010000",  "CC00000");          // abort with tick
    add_seq(6, 2'd2, "10000100000",      "",         "CCCC2CCCC20");      // no gap, back-to-back
    add_seq(7, 2'd1, "100010000000",     "",         "CCCCCCCC6440");     // retrigger on final ON cycle
    add_seq(8, 2'd0, "10001000",         "",         "CCCC7440");         // drop on final ON cycle
    add_seq(9, 2'd0, "10000000",         "00000100", "CCCC6000");         // abort during gap

    #2;
    for (int d = 0; d < 3; d++) check($sformatf("reset_dut%0d", d), outs(2'(d)), 4'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      tick  = 3'b000;
      abort = 3'b000;
      tick[vecs[i].sel]  = vecs[i].tick;
      abort[vecs[i].sel] = vecs[i].abort;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("s%0d_v%0d", e.scen, e.idx), outs(e.sel), e.exp);
    end
    @(negedge clk);
    tick  = 3'b000;
    abort = 3'b000;

    // Reset asserted mid-ON: outputs clear without waiting for an edge, no done tick afterwards.
    @(negedge clk);
    tick[0] = 1'b1;
    @(negedge clk);
    tick[0] = 1'b0;
    @(negedge clk);
    #1;
    check("pre_reset_on", outs(2'd0), 4'hC);
    #1 rst = 1'b1;
    #1;
    check("async_reset", outs(2'd0), 4'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset_c%0d", c), outs(2'd0), 4'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pulse_stretch_fsmd.md
Name: pulse_stretch_fsmd

Overview:
Output-side counterpart of the button debouncer. It turns a single-cycle event tick into a clean, fixed-length level pulse that is visible on an LED or usable as an OLED refresh/strobe, then enforces a minimum low gap before it accepts the next event. It sits between the reaction-timer control FSM and the LED or display-strobe outputs. It is an FSMD: a control FSM plus one down-counter data path.

Parameters:
N, 21, counter width in bits.
ON_CNT, 2000000, pulse high time in i_CLK cycles (20 ms at 100 MHz); legal range 1..2^N.
GAP_CNT, 1000000, enforced low time after a pulse, in cycles; legal range 0..2^N; 0 means no gap.
RETRIG, 0, 1 = a tick during ON restarts the high time; 0 = the tick is dropped.

Ports:
i_CLK  input  1  system clock
i_RST  input  1  reset
i_TICK  input  1  single-cycle event request
i_ABORT  input  1  synchronous cancel of any pulse or gap in progress
o_LVL  output  1  stretched pulse level
o_BUSY  output  1  high whenever state is not IDLE
o_DONE_TICK  output  1  one-cycle pulse marking a pulse that completed normally
o_DROP_TICK  output  1  one-cycle pulse marking a rejected i_TICK

Behaviour:
- Clocking and reset: clock i_CLK; reset i_RST, asynchronous, active-high. On reset: state = IDLE, counter = 0, all outputs = 0. Outputs clear immediately on reset, not at the next edge.
- All outputs are registered, with no combinational path from input to output.
  - o_LVL = (state == ON).
  - o_BUSY = (state != IDLE).
  - o_DONE_TICK and o_DROP_TICK are registered one cycle after their cause.
- States: IDLE, ON, GAP. The encoding is fixed by the shared package.
- IDLE:
  - i_TICK → ON; counter loads ON_CNT-1.
  - o_LVL rises in the cycle after the tick (latency 1).
- ON:
  - Counter decrements every cycle, so o_LVL is high for exactly ON_CNT cycles.
  - At counter == 0: go to GAP and load GAP_CNT-1. If GAP_CNT == 0, go to IDLE instead. o_DONE_TICK is high in the following cycle.
  - i_TICK with RETRIG=1: counter reloads ON_CNT-1 and the state stays ON. This applies on the final ON cycle too; in that case there is no done tick.
  - i_TICK with RETRIG=0: the tick is ignored and o_DROP_TICK is high next cycle.
- GAP:
  - Counter decrements; o_LVL stays low; o_BUSY stays high.
  - At counter == 0 → IDLE.
  - Any i_TICK in GAP, including the final GAP cycle, is dropped and o_DROP_TICK is high next cycle.
- i_ABORT:
  - From any state → IDLE at the next edge; counter clears to 0.
  - No o_DONE_TICK is produced.
  - Abort has priority over a simultaneous i_TICK. That tick is discarded silently, with no o_DROP_TICK.
- Width rules: counter is N bits and never decrements below 0. A load value of 2^N-1 is legal.
- Illegal-state recovery: any unused state encoding → IDLE.
- Reset asserted mid-ON or mid-GAP: o_LVL drops to 0 immediately and no done tick follows.

Decomposition:
- Shared package holds:
  - the state localparams (IDLE, ON, GAP, 2-bit);
  - default timing constants (ON_CNT_20MS, GAP_CNT_10MS at 100 MHz).
- One natural sub-module: load_dec_counter. It takes a load, a decrement and a clear, and reports a zero flag. Parameter N. It is reused by future timer blocks.
- The control FSM stays in pulse_stretch_fsmd.

Test Plan:
All scenarios use N=4, ON_CNT=4, GAP_CNT=3, and a tick at cycle t.
- Basic pulse, RETRIG=0: o_LVL high at t+1..t+4; o_DONE_TICK high at t+5 only; o_BUSY high t+1..t+7; IDLE (o_BUSY=0) at t+8.
- Dropped tick, RETRIG=0, second tick at t+2: o_DROP_TICK high at t+3; o_LVL timing identical to the basic pulse.
- Retrigger, RETRIG=1, second tick at t+3: no drop; o_LVL high t+1..t+7; o_DONE_TICK at t+8; IDLE at t+11.
- Gap enforcement: tick at t+6 gives o_DROP_TICK at t+7. A tick at t+8 gives a new pulse with o_LVL high t+9..t+12.
- Abort and reset:
  - i_ABORT at t+2 together with a tick: o_LVL=0 and o_BUSY=0 from t+3; no done tick; no drop tick.
  - i_RST asserted mid-ON: all outputs 0 immediately.
- GAP_CNT=0: ticks at t and t+5 give o_LVL high t+1..t+4 and t+6..t+9, with o_DONE_TICK at t+5 and t+10.
